output_result_buffer: RTL and testbench

Parametrised result buffer that sits at the output of the datapath and collects computed words by address. Adds over the previous fixed 8×32 output store: a registered read port, per-entry written tracking with an occupancy count, and a valid/ready dump sequencer that streams all entries in address order to a downstream consumer and then clears the batch. Memory contents are never reset; only control state is.

---
 rtl/output_result_buffer.sv | 120 ++++++++++++
 tb/tb_output_result_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_result_buffer.sv
// Output result buffer: address-indexed word store with a registered read port,
// written-entry tracking, and a valid/ready dump sequencer that clears the batch.
module output_result_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              dump_done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    written;
  logic                wr_ok;

  // Writes are locked out for the whole dump so the streamed batch is stable.
  assign wr_ok = wr_en && !dump_busy;
  assign full  = (count == CNT_W'(DEPTH));

  // Data storage carries no reset; the written mask decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Read port, written mask, occupancy and write-drop reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_drop  <= 1'b0;
      written  <= '0;
      count    <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= written[rd_addr] ? mem[rd_addr] : '0;
      wr_drop <= wr_en && dump_busy;
      if (state == DONE) begin
        written <= '0;
        count   <= '0;
      end else if (wr_ok) begin
        written[wr_addr] <= 1'b1;
        if (!written[wr_addr]) count <= count + CNT_W'(1);
      end
    end
  end

  // Dump sequencer: FETCH loads a beat, SEND holds it until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
      dump_last  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            state     <= FETCH;
            ptr       <= '0;
            dump_busy <= 1'b1;
          end
        end
        FETCH: begin
          dump_data  <= written[ptr] ? mem[ptr] : '0;
          dump_addr  <= ptr;
          dump_last  <= (ptr == ADDR_W'(DEPTH - 1));
          dump_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_last) begin
              dump_done <= 1'b1;
              state     <= DONE;
            end else begin
              ptr   <= ptr + ADDR_W'(1);
              state <= FETCH;
            end
          end
        end
        DONE: begin
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_result_buffer.sv
// Self-checking bench for output_result_buffer: directed plus randomized traffic
// compared against an array-based reference model.
module tb_output_result_buffer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_drop;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  count;
  logic        full;
  logic        dump_start;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [2:0]  dump_addr;
  logic        dump_last;
  logic        dump_done;

  output_result_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
    .dump_last(dump_last), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;

  logic [31:0] m_mem [8];
  bit          m_wr  [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_wr[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    return m_wr[a] ? m_mem[a] : 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model_mask();
    for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rd_data"},    rd_data,           32'h0);
    check({tag, ".rd_valid"},   32'(rd_valid),     32'h0);
    check({tag, ".wr_drop"},    32'(wr_drop),      32'h0);
    check({tag, ".count"},      32'(count),        32'h0);
    check({tag, ".full"},       32'(full),         32'h0);
    check({tag, ".dump_busy"},  32'(dump_busy),    32'h0);
    check({tag, ".dump_valid"}, 32'(dump_valid),   32'h0);
    check({tag, ".dump_data"},  dump_data,         32'h0);
    check({tag, ".dump_addr"},  32'(dump_addr),    32'h0);
    check({tag, ".dump_last"},  32'(dump_last),    32'h0);
    check({tag, ".dump_done"},  32'(dump_done),    32'h0);
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    rd_en = 0; rd_addr = '0;
    dump_start = 0; dump_ready = 0;
  endtask

  // One idle-state cycle with optional write and read; read expects pre-write contents.
  task automatic cycle_op(input string tag, input bit we, input int wa, input logic [31:0] wd,
                          input bit re, input int ra);
    logic [31:0] exp_rd;
    exp_rd  = m_read(ra);
    wr_en   = we; wr_addr = 3'(wa); wr_data = wd;
    rd_en   = re; rd_addr = 3'(ra);
    step();
    wr_en = 0; rd_en = 0;
    if (we) begin
      m_mem[wa] = wd;
      m_wr[wa]  = 1'b1;
    end
    if (re) begin
      check({tag, ".rd_valid"}, 32'(rd_valid), 32'h1);
      check({tag, ".rd_data"},  rd_data,       exp_rd);
    end
    check({tag, ".count"}, 32'(count), 32'(m_count()));
    check({tag, ".full"},  32'(full),  32'(m_count() == 8));
  endtask

  task automatic run_dump(input string tag, input bit rand_ready, input bit inject,
                          input int abort_at, input bit start_wr, input int swa,
                          input logic [31:0] swd);
    int          cyc, beats, done_cyc, first_valid;
    bit          done_seen, aborted, prev_stall;
    logic        rdy;
    logic [31:0] prev_data;
    logic [2:0]  prev_addr;
    dump_start = 1;
    if (start_wr) begin
      wr_en = 1; wr_addr = 3'(swa); wr_data = swd;
    end
    step();
    dump_start = 0; wr_en = 0;
    if (start_wr) begin
      m_mem[swa] = swd;
      m_wr[swa]  = 1'b1;
    end
    check({tag, ".busy_at_fetch"},  32'(dump_busy),  32'h1);
    check({tag, ".valid_at_fetch"}, 32'(dump_valid), 32'h0);
    cyc = 1; beats = 0; done_cyc = 0; first_valid = 0;
    done_seen = 0; aborted = 0; prev_stall = 0;
    prev_data = '0; prev_addr = '0;
    while (cyc < 200 && !done_seen && !aborted) begin
      if (prev_stall) begin
        check({tag, ".hold_valid"}, 32'(dump_valid), 32'h1);
        check({tag, ".hold_data"},  dump_data,       prev_data);
        check({tag, ".hold_addr"},  32'(dump_addr),  32'(prev_addr));
      end
      if (inject && cyc == 4) begin
        check({tag, ".wr_drop"},        32'(wr_drop), 32'h1);
        check({tag, ".count_in_dump"},  32'(count),   32'(m_count()));
        wr_en = 0; dump_start = 0;
      end
      if (dump_valid && first_valid == 0) first_valid = cyc;
      if (dump_done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end else if (abort_at >= 0 && beats == abort_at && dump_valid) begin
        aborted = 1;
      end else begin
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        dump_ready = rdy;
        if (dump_valid && rdy) begin
          check({tag, ".beat_addr"}, 32'(dump_addr), 32'(beats));
          check({tag, ".beat_data"}, dump_data,      m_read(beats));
          check({tag, ".beat_last"}, 32'(dump_last), 32'(beats == 7));
          beats++;
        end
        prev_stall = dump_valid && !rdy;
        prev_data  = dump_data;
        prev_addr  = dump_addr;
        if (inject && cyc == 3) begin
          wr_en = 1; wr_addr = 3'd1; wr_data = 32'h55; dump_start = 1;
        end
        step();
        cyc++;
      end
    end
    dump_ready = 0;
    if (aborted) begin
      rst_n = 0;
      #1;
      check_reset_outputs({tag, ".abort"});
      clear_model_mask();
      step();
      rst_n = 1;
      step();
      check({tag, ".idle_after_abort"}, 32'(dump_busy), 32'h0);
    end else begin
      check({tag, ".done_seen"}, 32'(done_seen), 32'h1);
      check({tag, ".beats"},     32'(beats),     32'h8);
      check({tag, ".busy_in_done"}, 32'(dump_busy), 32'h1);
      if (!rand_ready) begin
        check({tag, ".first_valid_cyc"}, 32'(first_valid), 32'd2);
        check({tag, ".done_cyc"},        32'(done_cyc),    32'd17);
        wr_en = 1; wr_addr = 3'd5; wr_data = 32'h77;
      end
      step();
      wr_en = 0;
      clear_model_mask();
      check({tag, ".busy_after"},  32'(dump_busy), 32'h0);
      check({tag, ".count_after"}, 32'(count),     32'h0);
      check({tag, ".done_pulse"},  32'(dump_done), 32'h0);
      if (!rand_ready) check({tag, ".drop_in_done"}, 32'(wr_drop), 32'h1);
    end
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = '0;
      m_wr[i]  = 1'b0;
    end
    rst_n = 0;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1;
    step();

    cycle_op("rd_unwritten", 0, 0, 32'h0, 1, 4);
    for (int i = 0; i < 8; i++) cycle_op("fill", 1, i, 32'hA0 + 32'(i), 0, 0);
    check("full_after_fill", 32'(full), 32'h1);
    cycle_op("rewrite3", 1, 3, 32'hFF, 0, 0);
    cycle_op("rd5", 0, 0, 32'h0, 1, 5);
    cycle_op("rbw2", 1, 2, 32'h11, 1, 2);
    cycle_op("rd2_new", 0, 0, 32'h0, 1, 2);

    for (int i = 0; i < 20; i++)
      cycle_op("rand_op", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom(),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));

    // Fresh batch: entries 0 and 2 only; entry 2 written alongside dump_start.
    rst_n = 0;
    #1;
    clear_model_mask();
    step();
    rst_n = 1;
    cycle_op("rd_after_rst", 0, 0, 32'h0, 1, 0);
    cycle_op("w0", 1, 0, 32'hA0, 0, 0);
    run_dump("dump_fixed", 0, 0, -1, 1, 2, 32'hA2);

    for (int i = 0; i < 5; i++)
      cycle_op("pre_rand", 1, int'($urandom_range(0, 7)), $urandom(), 0, 0);
    run_dump("dump_rand", 1, 1, -1, 0, 0, 32'h0);

    for (int i = 0; i < 8; i++) cycle_op("pre_abort", 1, i, $urandom(), 0, 0);
    run_dump("dump_abort", 0, 0, 4, 0, 0, 32'h0);
    cycle_op("rd_after_abort", 0, 0, 32'h0, 1, 6);
    run_dump("dump_zero", 0, 0, -1, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
